preg_free_list: RTL
===================

# preg_free_list

Physical-register free list for the rename stage: a circular FIFO of unallocated physical register indices. It hands out one new destination register per cycle at dispatch. It takes back the displaced mapping (`P_rd_old`) when the reorder buffer commits an instruction. During misprediction recovery it takes back up to two squashed `P_rd_new` per cycle. It sits between the rename/dispatch logic and the commit/rollback outputs of the reorder buffer.

## Interface
Parameters:
- `PREG_NUM`, 128: number of physical registers; 7-bit index.
- `AREG_NUM`, 64: architectural registers (32 int + 32 fp). Physical regs 0..AREG_NUM-1 are mapped at reset.
- `FL_DEPTH`, PREG_NUM-AREG_NUM = 64: FIFO depth. Must be a power of 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `alloc_req`  in  1  rename needs a destination register this cycle
- `alloc_valid`  out  1  a register is available and allocation is permitted
- `alloc_preg`  out  7  register granted on `alloc_req && alloc_valid`
- `stall`  in  1  ROB recovery in progress; blocks allocation
- `commit_wb_en`  in  1  committing instruction has a destination
- `commit_P_rd_old`  in  7  displaced register to free
- `rollback_en_0`  in  1  squash slot 0 valid
- `rollback_P_rd_new_0`  in  7  squashed register to free
- `rollback_en_1`  in  1  squash slot 1 valid
- `rollback_P_rd_new_1`  in  7  squashed register to free
- `free_count`  out  7  number of entries currently held (0..64)
- `overflow_err`  out  1  sticky; a push was attempted beyond FL_DEPTH
- `underflow_err`  out  1  sticky; `alloc_req` arrived while `count==0` and `stall==0`

## Operation
- Storage: `mem[0..63]` holds 7-bit indices; `head` (pop) and `tail` (push) are 6-bit and wrap naturally; `count` is 7-bit.
- Reset: `mem[i] = AREG_NUM+i`, `head=0`, `tail=0`, `count=64`, both error flags 0. After reset: `alloc_valid=1`, `alloc_preg=64`, `free_count=64`.
- `alloc_valid = (count!=0) && !stall`.
- `alloc_preg = mem[head]`.
- pop = `alloc_req && alloc_valid`. On pop, `head` advances by 1.
- Push candidates, in fixed order:
  - slot A: `rollback_en_0 && rollback_P_rd_new_0!=0`
  - slot B: `rollback_en_1 && rollback_P_rd_new_1!=0`
  - slot C: `commit_wb_en && commit_P_rd_old!=0`
- Valid pushes are compacted. The k-th valid push (k=0..2) writes `mem[tail+k]`. `tail` advances by `npush` (0..3).
- Index 0 is never pushed; a zero index is silently dropped.
- `count_next = count - pop + npush`.
- If `count - pop + npush > 64`: set `overflow_err`, write no entries, leave `tail` unchanged. The pop still completes.
- No duplicate-index checking; the verification scoreboard checks duplicates.

## Timing
- Allocation is zero-latency: `alloc_preg` is valid in the same cycle as `alloc_valid`. `head` updates at the next edge.
- A freed register is visible to allocation at the earliest on the cycle after its push. A same-cycle push never feeds `alloc_preg`.
- Pop and up to 3 pushes in one cycle are legal.
  - Pop reads `mem[head]`; pushes write at `tail`.
  - When `count==0`, `head==tail`, but pop is suppressed, so there is no read/write hazard.
  - When `count==64`, a push without an accompanying pop overflows.
- `stall` high suppresses pop only. Rollback pushes and commit pushes proceed during stall.
- `rst` asserted mid-operation restores the full reset state at the next edge, regardless of in-flight requests.
- Wrap-around: `tail+k` and `head+1` are computed modulo 64. There is no special casing at index 63.

## Structure
- `PREG_NUM`, `AREG_NUM`, and the derived width macros go in the shared defines header alongside `ROB_LEN`, not local to this block.
- One combinational sub-module, `fl_push_compactor`:
  - inputs: three (valid, index) pairs
  - outputs: three compacted write-enable/index lanes and `npush`
- The FIFO array, pointers, count, and error flags stay in `preg_free_list`.

## Test plan
- Reset and sequential drain: hold `alloc_req=1` for 64 cycles.
  - Grants are 64, 65, …, 127 in order.
  - Cycle 65: `alloc_valid=0`, `free_count=0`, `underflow_err` set if `alloc_req` is still high.
- Triple push with wrap: `tail=62`, `count=1`; push rollback0=70, rollback1=0, commit=90 in one cycle.
  - Result: `mem[62]=70`, `mem[63]=90`, `tail=0`, `count=3`.
  - Index 0 is dropped.
- Simultaneous pop and push at `count=1`: `head` holds 100; `alloc_req=1` and commit frees 5.
  - Grant is 100.
  - Next cycle: `alloc_preg=5`, `count=1`.
- Stall gating: `stall=1` with `alloc_req=1` and both rollback slots (77, 78).
  - `alloc_valid=0`, `head` unchanged, `count += 2`.
  - After `stall` drops, 77 and 78 are granted after all older entries.
- Overflow: at `count=64`, commit frees 9 with no pop.
  - `overflow_err=1` and stays sticky; `count=64`; `tail` unchanged.
  - `rst` pulse clears the flag and restores `alloc_preg=64`.
- Random dispatch/commit/rollback against a set-based scoreboard.
  - No index is granted twice without an intervening free.
  - `free_count` always equals the scoreboard's free-set size.

Source files
------------

// File: rtl/preg_free_list_pkg.sv
// Shared rename-stage definitions.
//   PREG_NUM / AREG_NUM / ROB_LEN : machine-wide sizes used by rename, ROB and free list
//   PREG_W, FL_DEPTH, FL_PTR_W, FL_CNT_W : widths derived from the sizes above
//   preg_t                         : physical register index type
//   push_ok()                      : a freed index is only worth pushing if enabled and non-zero
package preg_free_list_pkg;

  localparam int PREG_NUM = 128;
  localparam int AREG_NUM = 64;
  localparam int ROB_LEN  = 32;

  localparam int PREG_W   = $clog2(PREG_NUM);
  localparam int FL_DEPTH = PREG_NUM - AREG_NUM;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

  typedef logic [PREG_W-1:0] preg_t;

  // Physical register 0 is hard-wired and never recycled, so a zero index
  // is treated as "nothing to free".
  function automatic logic push_ok(input logic en, input preg_t idx);
    return en && (idx != '0);
  endfunction

endpackage

// File: rtl/preg_free_list_push.sv
// fl_push_compactor: packs up to three free requests into consecutive write lanes.
//   a_*, b_*, c_* : candidate (valid, index) pairs in priority order
//                   (rollback slot 0, rollback slot 1, commit)
//   we0..we2      : lane write enables; lane k is the k-th valid candidate
//   idx0..idx2    : lane indices
//   npush         : number of valid candidates (0..3)
// Purely combinational. Lane k is written to tail+k by the free list.
module fl_push_compactor
  import preg_free_list_pkg::*;
(
  input  logic        a_v,
  input  preg_t       a_idx,
  input  logic        b_v,
  input  preg_t       b_idx,
  input  logic        c_v,
  input  preg_t       c_idx,
  output logic        we0,
  output preg_t       idx0,
  output logic        we1,
  output preg_t       idx1,
  output logic        we2,
  output preg_t       idx2,
  output logic [1:0]  npush
);

  always_comb begin
    we0  = 1'b0;
    idx0 = '0;
    we1  = 1'b0;
    idx1 = '0;
    we2  = 1'b0;
    idx2 = '0;

    // Lane 0: first valid candidate in priority order.
    if (a_v) begin
      we0  = 1'b1;
      idx0 = a_idx;
    end else if (b_v) begin
      we0  = 1'b1;
      idx0 = b_idx;
    end else if (c_v) begin
      we0  = 1'b1;
      idx0 = c_idx;
    end

    // Lane 1: B behind A, or C behind exactly one of A/B.
    if (a_v && b_v) begin
      we1  = 1'b1;
      idx1 = b_idx;
    end else if ((a_v ^ b_v) && c_v) begin
      we1  = 1'b1;
      idx1 = c_idx;
    end

    // Lane 2: only reachable when all three are valid.
    if (a_v && b_v && c_v) begin
      we2  = 1'b1;
      idx2 = c_idx;
    end

    npush = 2'({1'b0, a_v} + {1'b0, b_v} + {1'b0, c_v});
  end

endmodule

// File: rtl/preg_free_list.sv
// preg_free_list: circular FIFO of unallocated physical register indices.
//   clk, rst             : clock, synchronous active-high reset
//   alloc_req            : rename wants one destination register this cycle
//   alloc_valid          : a register is available and stall is low
//   alloc_preg           : head entry; granted when alloc_req && alloc_valid
//   stall                : ROB recovery in progress; blocks allocation only
//   commit_wb_en/_P_rd_old          : displaced mapping freed at commit
//   rollback_en_0/_P_rd_new_0       : squashed destination freed, slot 0
//   rollback_en_1/_P_rd_new_1       : squashed destination freed, slot 1
//   free_count           : entries currently held (0..FL_DEPTH)
//   overflow_err         : sticky, a push would have exceeded FL_DEPTH
//   underflow_err        : sticky, alloc_req while empty and not stalled
// Handshake: a grant happens in exactly the cycle alloc_req && alloc_valid
// are both high at the clock edge; alloc_preg is valid whenever alloc_valid
// is high, and the head advances on that edge. Frees have no back-pressure.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_req,
  output logic                alloc_valid,
  output logic [PREG_W-1:0]   alloc_preg,
  input  logic                stall,
  input  logic                commit_wb_en,
  input  logic [PREG_W-1:0]   commit_P_rd_old,
  input  logic                rollback_en_0,
  input  logic [PREG_W-1:0]   rollback_P_rd_new_0,
  input  logic                rollback_en_1,
  input  logic [PREG_W-1:0]   rollback_P_rd_new_1,
  output logic [FL_CNT_W-1:0] free_count,
  output logic                overflow_err,
  output logic                underflow_err
);

  preg_t                mem [FL_DEPTH];
  logic [FL_PTR_W-1:0]  head;
  logic [FL_PTR_W-1:0]  tail;
  logic [FL_CNT_W-1:0]  count;

  logic                 pop;
  logic                 we0;
  logic                 we1;
  logic                 we2;
  preg_t                idx0;
  preg_t                idx1;
  preg_t                idx2;
  logic [1:0]           npush;
  logic [FL_CNT_W:0]    count_sum;
  logic                 push_ovf;
  logic [FL_PTR_W-1:0]  tail_p1;
  logic [FL_PTR_W-1:0]  tail_p2;

  fl_push_compactor u_push (
    .a_v   (push_ok(rollback_en_0, rollback_P_rd_new_0)),
    .a_idx (rollback_P_rd_new_0),
    .b_v   (push_ok(rollback_en_1, rollback_P_rd_new_1)),
    .b_idx (rollback_P_rd_new_1),
    .c_v   (push_ok(commit_wb_en, commit_P_rd_old)),
    .c_idx (commit_P_rd_old),
    .we0   (we0),
    .idx0  (idx0),
    .we1   (we1),
    .idx1  (idx1),
    .we2   (we2),
    .idx2  (idx2),
    .npush (npush)
  );

  assign alloc_valid = (count != '0) && !stall;
  assign alloc_preg  = mem[head];
  assign free_count  = count;
  assign pop         = alloc_req && alloc_valid;

  // One extra bit so a full list plus pushes does not wrap before the
  // overflow compare. count - pop never goes negative: pop needs count != 0.
  assign count_sum = {1'b0, count} - (FL_CNT_W+1)'(pop) + (FL_CNT_W+1)'(npush);
  assign push_ovf  = count_sum > (FL_CNT_W+1)'(FL_DEPTH);

  // Pointers are log2(FL_DEPTH) wide, so these wrap at the end of the array.
  assign tail_p1 = tail + FL_PTR_W'(1);
  assign tail_p2 = tail + FL_PTR_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= PREG_W'(AREG_NUM + i);
      end
      head          <= '0;
      tail          <= '0;
      count         <= FL_CNT_W'(FL_DEPTH);
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (pop) begin
        head <= head + FL_PTR_W'(1);
      end

      if (push_ovf) begin
        // Whole push group is discarded; the pop still retires.
        overflow_err <= 1'b1;
        count        <= count - FL_CNT_W'(pop);
      end else begin
        if (we0) mem[tail]    <= idx0;
        if (we1) mem[tail_p1] <= idx1;
        if (we2) mem[tail_p2] <= idx2;
        tail  <= tail + FL_PTR_W'(npush);
        count <= count_sum[FL_CNT_W-1:0];
      end

      if (alloc_req && (count == '0) && !stall) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule
